// File: rtl/spi_cfg_regfile.sv
// SPI mode-3 slave with a 64 x 8-bit configuration register file.
// Everything is clocked by SCK; the register image is exported flat on cfg_data.
module spi_cfg_regfile (
    input  logic         SCK,
    input  logic         NRST,
    input  logic         CS,
    input  logic         PICO,
    output logic         POCI,
    input  logic [13:0]  status,
    output logic [511:0] cfg_data
);

    localparam logic [1:0] OP_RDREG = 2'b00;
    localparam logic [1:0] OP_WRREG = 2'b10;

    // Frame-scoped state (bit counter, pending read) is held clear while CS is high.
    logic frame_rst_b;
    assign frame_rst_b = NRST & ~CS;

    logic [3:0]  bitcnt_q;
    logic [3:0]  bitcnt_d;
    logic [14:0] shift_q;
    logic        pend_rd_q;
    logic [5:0]  rd_addr_q;
    logic [7:0]  regs_q [64];
    logic        poci_q;

    logic [15:0] word_d;
    logic        word_done;
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [7:0]  data;
    logic        wr_en;
    logic [15:0] response;

    assign word_d    = {shift_q, PICO};
    assign op        = word_d[15:14];
    assign addr      = word_d[13:8];
    assign data      = word_d[7:0];
    assign word_done = !CS && (bitcnt_q == 4'd15);
    assign wr_en     = word_done && (op == OP_WRREG);
    assign bitcnt_d  = bitcnt_q + 4'd1;

    always_ff @(posedge SCK or negedge frame_rst_b) begin
        if (!frame_rst_b) begin
            bitcnt_q  <= 4'd0;
            pend_rd_q <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            if (word_done) begin
                pend_rd_q <= (op == OP_RDREG);
            end
        end
    end

    always_ff @(posedge SCK or negedge NRST) begin
        if (!NRST) begin
            shift_q   <= 15'd0;
            rd_addr_q <= 6'd0;
        end else if (!CS) begin
            shift_q <= word_d[14:0];
            if (word_done) begin
                rd_addr_q <= addr;
            end
        end
    end

    always_ff @(posedge SCK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs_q[addr] <= data;
        end
    end

    // Read data is sampled live each time a bit is shifted out.
    always_comb begin
        response = {2'b00, status};
        if (pend_rd_q) begin
            response = {8'h00, regs_q[rd_addr_q]};
        end
    end

    always_ff @(negedge SCK or negedge NRST) begin
        if (!NRST) begin
            poci_q <= 1'b0;
        end else if (!CS) begin
            poci_q <= response[4'd15 - bitcnt_q];
        end
    end

    assign POCI = poci_q;

    for (genvar g = 0; g < 64; g++) begin : g_cfg
        assign cfg_data[g*8 +: 8] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Bench for spi_cfg_regfile: drives SPI mode-3 frames and compares responses
// and the register image against a word-level model of the register file.
module tb_spi_cfg_regfile;

    logic         SCK  = 1'b1;
    logic         NRST = 1'b0;
    logic         CS   = 1'b1;
    logic         PICO = 1'b0;
    logic [13:0]  status = 14'd0;
    logic         POCI;
    logic [511:0] cfg_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_reg [64];
    logic       m_pend;
    logic [5:0] m_rd;

    spi_cfg_regfile dut (
        .SCK      (SCK),
        .NRST     (NRST),
        .CS       (CS),
        .PICO     (PICO),
        .POCI     (POCI),
        .status   (status),
        .cfg_data (cfg_data)
    );

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
        m_pend = 1'b0;
        m_rd   = 6'd0;
    endtask

    // Response for this word follows from the previous word; then apply this word.
    task automatic model_word(input logic [15:0] w, output logic [15:0] resp);
        resp = m_pend ? {8'h00, m_reg[m_rd]} : {2'b00, status};
        if (w[15:14] == 2'b10) m_reg[w[13:8]] = w[7:0];
        m_pend = (w[15:14] == 2'b00);
        m_rd   = w[13:8];
    endtask

    function automatic logic [511:0] model_cfg();
        logic [511:0] v;
        for (int i = 0; i < 64; i++) v[i*8 +: 8] = m_reg[i];
        return v;
    endfunction

    task automatic shift_word(input logic [15:0] w, input int nbits, output logic [15:0] rsp);
        rsp = 16'h0000;
        for (int i = 15; i > 15 - nbits; i--) begin
            #5 SCK = 1'b0;
            PICO = w[i];
            #4 rsp[i] = POCI;
            #1 SCK = 1'b1;
        end
    endtask

    task automatic cs_low();
        #5 CS = 1'b0;
    endtask

    task automatic cs_high();
        #5 CS = 1'b1;
        m_pend = 1'b0;
        #5;
    endtask

    task automatic run_frame(input logic [15:0] ws [4], input int n,
                             output logic [15:0] rs [4], output logic [15:0] es [4]);
        logic [15:0] r, e;
        for (int k = 0; k < 4; k++) begin rs[k] = 16'h0; es[k] = 16'h0; end
        cs_low();
        for (int k = 0; k < n; k++) begin
            model_word(ws[k], e);
            shift_word(ws[k], 16, r);
            rs[k] = r;
            es[k] = e;
        end
        cs_high();
    endtask

    task automatic test_reset();
        NRST = 1'b0;
        #10 NRST = 1'b1;
        model_reset();
        #5;
        checks++;
        if (cfg_data !== 512'd0) begin
            failures++;
            $display("FAIL reset_cfg: got %h required 0", cfg_data);
        end
        checks++;
        if (POCI !== 1'b0) begin
            failures++;
            $display("FAIL reset_poci: got %b required 0", POCI);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ws [4];
        logic [15:0] rs [4];
        logic [15:0] es [4];
        logic [15:0] req [4];
        status = 14'h0000;
        ws = '{16'h2300, 16'h0000, 16'h0, 16'h0};
        run_frame(ws, 2, rs, es);
        req = '{16'h0000, 16'h0000, 16'h0, 16'h0};
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rs[k] !== req[k]) begin
                failures++;
                $display("FAIL rd_empty w%0d: got %h required %h", k, rs[k], req[k]);
            end
        end
        ws = '{16'hA380, 16'h0, 16'h0, 16'h0};
        run_frame(ws, 1, rs, es);
        checks++;
        if (cfg_data[8'h23*8 +: 8] !== 8'h80) begin
            failures++;
            $display("FAIL wr_23: got %h required 80", cfg_data[8'h23*8 +: 8]);
        end
        ws = '{16'h2300, 16'h0000, 16'h0, 16'h0};
        run_frame(ws, 2, rs, es);
        checks++;
        if (rs[1] !== 16'h0080) begin
            failures++;
            $display("FAIL rd_23: got %h required 0080", rs[1]);
        end
        ws = '{16'h9B10, 16'h0, 16'h0, 16'h0};
        run_frame(ws, 1, rs, es);
        checks++;
        if (cfg_data[8'h1B*8 +: 8] !== 8'h10 || cfg_data[8'h23*8 +: 8] !== 8'h80) begin
            failures++;
            $display("FAIL wr_1b: got 1b=%h 23=%h required 10/80",
                     cfg_data[8'h1B*8 +: 8], cfg_data[8'h23*8 +: 8]);
        end
        ws = '{16'h1B00, 16'h0000, 16'h0, 16'h0};
        run_frame(ws, 2, rs, es);
        checks++;
        if (rs[1] !== 16'h0010) begin
            failures++;
            $display("FAIL rd_1b: got %h required 0010", rs[1]);
        end
        status = 14'h2ABC;
        ws = '{16'h0000, 16'h0, 16'h0, 16'h0};
        run_frame(ws, 1, rs, es);
        checks++;
        if (rs[0] !== 16'h2ABC) begin
            failures++;
            $display("FAIL status: got %h required 2abc", rs[0]);
        end
        ws = '{16'h4000, 16'h0000, 16'h0, 16'h0};
        run_frame(ws, 2, rs, es);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rs[k] !== 16'h2ABC) begin
                failures++;
                $display("FAIL reserved w%0d: got %h required 2abc", k, rs[k]);
            end
        end
        ws = '{16'h2300, 16'h1B00, 16'h0000, 16'h0};
        run_frame(ws, 3, rs, es);
        req = '{16'h2ABC, 16'h0080, 16'h0010, 16'h0};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rs[k] !== req[k]) begin
                failures++;
                $display("FAIL pipeline w%0d: got %h required %h", k, rs[k], req[k]);
            end
        end
    endtask

    task automatic test_abort();
        logic [15:0] r;
        logic [15:0] ws [4];
        logic [15:0] rs [4];
        logic [15:0] es [4];
        cs_low();
        shift_word(16'h85FF, 10, r);
        cs_high();
        checks++;
        if (cfg_data !== model_cfg()) begin
            failures++;
            $display("FAIL abort_nowrite: got reg05=%h required %h", cfg_data[5*8 +: 8], m_reg[5]);
        end
        ws = '{16'h8511, 16'h0, 16'h0, 16'h0};
        run_frame(ws, 1, rs, es);
        checks++;
        if (cfg_data[5*8 +: 8] !== 8'h11) begin
            failures++;
            $display("FAIL abort_then_wr: got %h required 11", cfg_data[5*8 +: 8]);
        end
    endtask

    task automatic test_poci_hold();
        logic p;
        p = POCI;
        for (int k = 0; k < 3; k++) begin
            #5 SCK = 1'b0;
            #5 SCK = 1'b1;
        end
        #2;
        checks++;
        if (POCI !== p) begin
            failures++;
            $display("FAIL poci_hold: got %b required %b", POCI, p);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ws [4];
        logic [15:0] rs [4];
        logic [15:0] es [4];
        ws = '{16'h8A5C, 16'h0A00, 16'hFFFF, 16'h0};
        run_frame(ws, 3, rs, es);
        checks++;
        if (rs[2] !== 16'h005C || rs[2] !== es[2]) begin
            failures++;
            $display("FAIL wr_then_rd: got %h required 005c", rs[2]);
        end
    endtask

    task automatic test_random();
        logic [15:0] ws [4];
        logic [15:0] rs [4];
        logic [15:0] es [4];
        int n;
        for (int f = 0; f < 40; f++) begin
            status = 14'($urandom);
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) begin
                ws[k] = 16'($urandom);
                if ($urandom_range(0, 1) == 0) ws[k][13:12] = 2'b00;
            end
            run_frame(ws, n, rs, es);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (rs[k] !== es[k]) begin
                    failures++;
                    $display("FAIL rand f%0d w%0d cmd=%h: got %h required %h",
                             f, k, ws[k], rs[k], es[k]);
                end
            end
            checks++;
            if (cfg_data !== model_cfg()) begin
                failures++;
                $display("FAIL rand_cfg f%0d: got %h required %h", f, cfg_data, model_cfg());
            end
        end
    endtask

    task automatic test_nrst_mid();
        logic [15:0] r, e;
        ws_loop: for (int k = 0; k < 4; k++) begin
            logic [15:0] ws [4];
            logic [15:0] rs [4];
            logic [15:0] es [4];
            ws = '{{2'b10, 6'(k * 9 + 1), 8'hC3}, 16'h0, 16'h0, 16'h0};
            run_frame(ws, 1, rs, es);
        end
        status = 14'h1234;
        cs_low();
        model_word(16'h0A00, e);
        shift_word(16'h0A00, 16, r);
        #2 NRST = 1'b0;
        #3 NRST = 1'b1;
        model_reset();
        checks++;
        if (cfg_data !== 512'd0) begin
            failures++;
            $display("FAIL nrst_cfg: got %h required 0", cfg_data);
        end
        model_word(16'h0000, e);
        shift_word(16'h0000, 16, r);
        cs_high();
        checks++;
        if (r !== 16'h1234 || r !== e) begin
            failures++;
            $display("FAIL nrst_resp: got %h required 1234", r);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_poci_hold();
        test_back_to_back();
        test_random();
        test_nrst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
